// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - keypad door lock sequencer with auto-relock and lockout
// Collects digits, checks them against PASSWORD on ENTER, and times OPEN and LOCKOUT.
module doorlock_ctrl #(
  parameter int                      PW_DIGITS   = 4,
  parameter logic [4*PW_DIGITS-1:0]  PASSWORD    = 16'h1234,
  parameter int                      OPEN_CYCLES = 16,
  parameter int                      LOCK_CYCLES = 32,
  parameter int                      MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] state_out,
  output logic       door_open,
  output logic [1:0] seg_out,
  output logic [3:0] digit_cnt,
  output logic [2:0] fail_cnt
);

  localparam int BW   = 4 * PW_DIGITS;
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ENTRY   = 2'b01,
    S_OPEN    = 2'b10,
    S_LOCKOUT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      fail_q, fail_d;
  logic            over_q, over_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            is_digit;
  logic            is_match;
  logic [2:0]      fail_inc;

  assign is_digit = key_valid && (key_code < 4'hA);
  assign is_match = (cnt_q == 4'(PW_DIGITS)) && (buf_q == PASSWORD) && !over_q;
  assign fail_inc = fail_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      over_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      over_q  <= over_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    over_d  = over_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          buf_d   = BW'(key_code);
          cnt_d   = 4'd1;
          over_d  = 1'b0;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (is_digit) begin
          // Digits past the password length are dropped but poison the entry.
          if (cnt_q < 4'(PW_DIGITS)) begin
            buf_d = (buf_q << 4) | BW'(key_code);
            cnt_d = cnt_q + 4'd1;
          end else begin
            over_d = 1'b1;
          end
        end else if (key_valid && key_code == KEY_CLEAR) begin
          buf_d   = '0;
          cnt_d   = '0;
          over_d  = 1'b0;
          state_d = S_IDLE;
        end else if (key_valid && key_code == KEY_ENTER) begin
          buf_d  = '0;
          cnt_d  = '0;
          over_d = 1'b0;
          if (is_match) begin
            fail_d  = '0;
            timer_d = TW'(OPEN_CYCLES - 1);
            state_d = S_OPEN;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == 3'(MAX_FAIL)) begin
              timer_d = TW'(LOCK_CYCLES - 1);
              state_d = S_LOCKOUT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_OPEN: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seg_out = 2'b10;
    unique case (state_q)
      S_IDLE:    seg_out = 2'b10;
      S_ENTRY:   seg_out = 2'b00;
      S_OPEN:    seg_out = 2'b01;
      S_LOCKOUT: seg_out = 2'b11;
      default:   seg_out = 2'b10;
    endcase
  end

  assign state_out = state_q;
  assign door_open = (state_q == S_OPEN);
  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb/tb_doorlock_ctrl.sv - randomized and directed bench for doorlock_ctrl
module tb_doorlock_ctrl;

  localparam int          PW      = 4;
  localparam logic [15:0] PWV     = 16'h1234;
  localparam int          OPEN_N  = 16;
  localparam int          LOCK_N  = 32;
  localparam int          MAXF    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] state_out;
  logic       door_open;
  logic [1:0] seg_out;
  logic [3:0] digit_cnt;
  logic [2:0] fail_cnt;

  doorlock_ctrl #(
    .PW_DIGITS(PW), .PASSWORD(PWV), .OPEN_CYCLES(OPEN_N),
    .LOCK_CYCLES(LOCK_N), .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .state_out(state_out), .door_open(door_open), .seg_out(seg_out),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: mode 0 idle, 1 entry, 2 open, 3 lockout; digits kept as a list.
  int m_mode  = 0;
  int m_fails = 0;
  int m_rem   = 0;
  bit m_over  = 0;
  int m_q[$];
  int seg_tab[4] = '{2, 0, 1, 3};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pw_digit(input int i);
    logic [15:0] p;
    p = PWV;
    return int'(p[4*(PW-1-i) +: 4]);
  endfunction

  task automatic model_step(input logic v, input logic [3:0] c, input logic r);
    bit match;
    if (r) begin
      m_mode = 0; m_fails = 0; m_rem = 0; m_over = 0; m_q.delete();
      return;
    end
    case (m_mode)
      0: if (v && c < 10) begin
        m_q.delete(); m_q.push_back(int'(c)); m_over = 0; m_mode = 1;
      end
      1: if (v) begin
        if (c < 10) begin
          if (m_q.size() < PW) m_q.push_back(int'(c));
          else m_over = 1;
        end else if (c == 4'hB) begin
          m_q.delete(); m_over = 0; m_mode = 0;
        end else if (c == 4'hA) begin
          match = (m_q.size() == PW) && !m_over;
          for (int i = 0; i < m_q.size(); i++)
            if (m_q[i] != pw_digit(i)) match = 0;
          m_q.delete(); m_over = 0;
          if (match) begin
            m_fails = 0; m_rem = OPEN_N; m_mode = 2;
          end else begin
            m_fails++;
            if (m_fails == MAXF) begin
              m_rem = LOCK_N; m_mode = 3;
            end else begin
              m_mode = 0;
            end
          end
        end
      end
      2: begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
      default: begin
        m_rem--;
        if (m_rem == 0) begin m_mode = 0; m_fails = 0; end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state_out", int'(state_out), m_mode);
    check("door_open", int'(door_open), (m_mode == 2) ? 1 : 0);
    check("seg_out",   int'(seg_out),   seg_tab[m_mode]);
    check("digit_cnt", int'(digit_cnt), m_q.size());
    check("fail_cnt",  int'(fail_cnt),  m_fails);
  endtask

  task automatic tick(input logic v, input logic [3:0] c, input logic r);
    key_valid = v; key_code = c; rst = r;
    @(posedge clk);
    model_step(v, c, r);
    @(negedge clk);
    key_valid = 1'b0; rst = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic send(input int n, input logic [31:0] keys);
    for (int i = n - 1; i >= 0; i--) tick(1'b1, keys[4*i +: 4], 1'b0);
  endtask

  initial begin
    int opens;
    logic [3:0] c;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    @(negedge clk);
    tick(1'b0, 4'h0, 1'b1);
    check("reset_state", int'(state_out), 0);
    check("reset_seg", int'(seg_out), 2);
    check("reset_door", int'(door_open), 0);

    // Correct code opens for exactly 16 cycles.
    tick(1'b1, 4'h1, 1'b0);
    check("first_digit_state", int'(state_out), 1);
    send(4, 32'h234A);
    check("open_state", int'(state_out), 2);
    opens = int'(door_open);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      opens += int'(door_open);
    end
    check("open_cycles", opens, 16);
    check("relock_seg", int'(seg_out), 2);

    // Three wrong entries lock out; keys are ignored meanwhile.
    send(5, 32'h1235A);
    check("fail1", int'(fail_cnt), 1);
    send(5, 32'h1235A);
    check("fail2", int'(fail_cnt), 2);
    send(5, 32'h1235A);
    check("lock_state", int'(state_out), 3);
    check("lock_seg", int'(seg_out), 3);
    send(5, 32'h1234A);
    check("lock_ignores", int'(door_open), 0);
    idle(40);
    check("lock_exit_fail", int'(fail_cnt), 0);
    check("lock_exit_state", int'(state_out), 0);

    // CLEAR then a good entry.
    send(3, 32'h12B);
    check("clear_cnt", int'(digit_cnt), 0);
    check("clear_state", int'(state_out), 0);
    send(5, 32'h1234A);
    check("after_clear_open", int'(state_out), 2);
    idle(20);

    // Short and overlong entries.
    send(4, 32'h123A);
    check("short_fail", int'(fail_cnt), 1);
    send(5, 32'h12345);
    check("overlong_cnt", int'(digit_cnt), 4);
    tick(1'b1, 4'hA, 1'b0);
    check("overlong_fail", int'(fail_cnt), 2);
    check("overlong_closed", int'(door_open), 0);
    send(5, 32'h1234A);
    check("good_after_fails", int'(fail_cnt), 0);
    check("good_after_fails_open", int'(door_open), 1);
    idle(20);

    // Ignored keys in IDLE and ENTRY.
    tick(1'b1, 4'hA, 1'b0);
    for (int k = 12; k < 16; k++) tick(1'b1, 4'(k), 1'b0);
    tick(1'b0, 4'h1, 1'b0);
    check("ignored_idle", int'(state_out), 0);
    tick(1'b1, 4'h1, 1'b0);
    for (int k = 12; k < 16; k++) tick(1'b1, 4'(k), 1'b0);
    tick(1'b0, 4'h2, 1'b0);
    check("ignored_entry_cnt", int'(digit_cnt), 1);
    tick(1'b1, 4'hB, 1'b0);

    // Reset mid-OPEN and mid-LOCKOUT.
    send(5, 32'h1234A);
    idle(4);
    tick(1'b0, 4'h0, 1'b1);
    check("rst_open_door", int'(door_open), 0);
    check("rst_open_seg", int'(seg_out), 2);
    for (int i = 0; i < 3; i++) send(5, 32'h1235A);
    idle(5);
    check("pre_rst_lock", int'(state_out), 3);
    tick(1'b1, 4'h1, 1'b1);
    check("rst_lock_state", int'(state_out), 0);
    check("rst_lock_fail", int'(fail_cnt), 0);

    // Randomized traffic, with occasional correct codes and resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        send(5, 32'h1234A);
      end else if ($urandom_range(0, 29) == 0) begin
        send(4, {$urandom_range(0, 9) == 0 ? 4'h7 : 4'h1, 12'h23A} );
      end else begin
        c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                        : 4'($urandom_range(0, 9));
        tick(1'($urandom_range(0, 1)), c, ($urandom_range(0, 299) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
